// File: rtl/fsabc_pkg.sv
// rtl/fsabc_pkg.sv - shared state type and sweep constants for the Gray-code sweep controller
package fsabc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } sweep_state_t;

  // Visit order of {A,B,C}; neighbouring entries differ in exactly one bit.
  localparam logic [2:0] GRAY_SEQ [0:7] = '{
    3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
  };

  localparam int DWELL_MAX = 255;

  function automatic int dwell_width(input int dwell);
    return $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/fsabc_dwell_timer.sv
// rtl/fsabc_dwell_timer.sv - loadable saturating down-counter that times each vector's dwell
module fsabc_dwell_timer
  import fsabc_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int W = dwell_width(DWELL);
  localparam logic [W-1:0] RELOAD = W'(DWELL - 1);

  logic [W-1:0] count;

  // Holds at zero rather than wrapping so a late enable cannot restart the dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fsabc_sweep_ctrl.sv
// rtl/fsabc_sweep_ctrl.sv - drives {A,B,C} through a Gray sweep and captures F as a truth table
// Optional abort input is built when FSABC_SWEEP_ABORT_EN is defined.
module fsabc_sweep_ctrl
  import fsabc_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef FSABC_SWEEP_ABORT_EN
  input  logic       abort,
`endif
  input  logic       f_i,
  output logic [2:0] abc_o,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_o
);

  if (DWELL < 1 || DWELL > DWELL_MAX) begin : g_bad_dwell
    $error("fsabc_sweep_ctrl: DWELL must be within 1..%0d", DWELL_MAX);
  end

  sweep_state_t state;
  logic [2:0]   step;
  logic         abort_req;
  logic         tmr_load;
  logic         tmr_en;
  logic         tmr_zero;

`ifdef FSABC_SWEEP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign tmr_en   = (state == ST_SETTLE);
  assign tmr_load = ((state == ST_IDLE) && start) ||
                    ((state == ST_SAMPLE) && (step != 3'd7) && !abort_req);

  fsabc_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      step    <= '0;
      abc_o   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      truth_o <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            truth_o <= '0;
            step    <= '0;
            abc_o   <= GRAY_SEQ[0];
            busy    <= 1'b1;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort_req) begin
            abc_o <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (tmr_zero) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // An abort here wins over the capture, so the pending bit is dropped.
          if (abort_req) begin
            abc_o <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            truth_o[GRAY_SEQ[step]] <= f_i;
            if (step == 3'd7) begin
              abc_o <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              step  <= step + 3'd1;
              abc_o <= GRAY_SEQ[step + 3'd1];
              state <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fsabc_sweep_ctrl.md
# fsabc_sweep_ctrl

Sequencer that drives the 3-input function block (inputs A, B, C; output F) through all eight input combinations in Gray-code order. It holds each vector for a programmable dwell, samples F, and assembles the function's 8-bit truth table. It sits between a host/start source and the combinational function under exercise, replacing hand-timed stimulus with a repeatable, cycle-exact sweep.

## Interface
- `DWELL`, default 10: cycles each vector is held before F is sampled. Legal range is 1..255; 0 is illegal.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a sweep. Accepted only in IDLE.
- `f_i` in 1: F output of the function block.
- `abc_o` out 3: drives {A,B,C}. A is the MSB.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when the sweep completes.
- `truth_o` out 8: captured truth table. Bit n holds F for {A,B,C} = n.
- `abort` in 1: present only with `FSABC_SWEEP_ABORT_EN` (see Configuration).

## Operation
- Gray order, steps 0..7: 000, 001, 011, 010, 110, 111, 101, 100. Exactly one input toggles per step.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Outputs: `abc_o`=000, `busy`=0.
  - On `start`=1: clear `truth_o` to 0, set step=0, load dwell counter with DWELL-1, go to SETTLE.
- SETTLE:
  - `abc_o`=GRAY[step], `busy`=1.
  - Counter decrements each cycle. When it is 0, go to SAMPLE.
- SAMPLE:
  - `abc_o`=GRAY[step], `busy`=1.
  - On exit, write `f_i` into `truth_o[GRAY[step]]`.
  - If step==7, go to DONE. Otherwise step+1, reload counter, go to SETTLE.
- DONE:
  - Outputs: `done`=1, `busy`=0, `abc_o`=000.
  - Go to IDLE unconditionally.
- `start` is ignored in SETTLE, SAMPLE and DONE. No queuing.
- `truth_o` holds its value in IDLE until the next accepted `start`.
- Step counter is 3 bits. Dwell counter is $clog2(DWELL+1) bits; it never wraps below 0.
- Reset values: `abc_o`=000, `busy`=0, `done`=0, `truth_o`=8'h00, state=IDLE.
- Reset mid-sweep: all outputs take their reset values immediately (asynchronous). No `done` is produced.

## Timing
- The edge that samples `start` in IDLE is edge k.
  - `busy` and `abc_o`=000 are valid from edge k.
  - Step s occupies edges k+s(DWELL+1) through k+(s+1)(DWELL+1).
- Each vector is stable for DWELL+1 cycles. `f_i` is sampled at the last edge of that window, so F has at least DWELL cycles to settle.
- `done` is high for one cycle starting at edge k+8(DWELL+1).
- `start` high in the `done` cycle is ignored. `start` high in the following cycle (IDLE) is accepted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `FSABC_SWEEP_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 in SETTLE or SAMPLE: next edge goes to IDLE with `abc_o`=000 and `busy`=0.
  - No `done`. `truth_o` retains the bits captured so far. A sample pending in that same SAMPLE cycle is discarded.
  - `abort` in IDLE or DONE has no effect.
  - `abort` and `start` together in IDLE: `start` wins.
- `FSABC_SWEEP_ABORT_EN` undefined: no `abort` port. A sweep always runs to completion or reset.

## Structure
- Shared package `fsabc_pkg`:
  - State enum `sweep_state_t`.
  - Constant array `GRAY_SEQ[0:7]` of 3-bit values.
  - `DWELL_MAX` = 255.
- Sub-module `fsabc_dwell_timer`: loadable down-counter with `load`, `zero` outputs and width derived from DWELL. Instantiated once.
- Top level holds the FSM, step counter, and `truth_o` register.

## Test plan
- DWELL=10, F = majority(A,B,C), pulse `start` -> `abc_o` follows 000,001,011,010,110,111,101,100. Each vector held 11 cycles. `done` pulses 88 cycles after the accept edge. `truth_o`=8'hE8.
- DWELL=1, F = A^B^C -> each vector held 2 cycles, `done` after 16 cycles, `truth_o`=8'h96. Every `abc_o` change flips exactly one bit.
- `start` held high throughout a sweep -> no restart while busy. A second sweep begins the cycle after `done`. `truth_o` is cleared to 0 at that accept edge.
- `rst_n` low at step 4 -> `abc_o`=000, `busy`=0, `truth_o`=00 immediately. No `done`. A fresh `start` after release gives a full 8-step sweep.
- With ABORT_EN, F=1, `abort` during step 3 SETTLE -> IDLE next edge. `truth_o`=8'h0B (bits 0,1,3 set). No `done`.
- `f_i` toggling during SETTLE but stable in the final cycle -> captured value equals the value at the SAMPLE exit edge.
